cdu_count_bank: RTL

- Parametrised multi-channel CDU counter bank that sits between the per-axis angle tracking loops and the AGC counter interface.
- Per channel it holds a read counter (the CDU angle register) and a signed pending-pulse counter, both fed by single-cycle up/down increments from the tracking loop.
- Pending counts are drained to the AGC as rate-limited single-cycle count pulses, one pulse slot every DIV clocks.
- Generalises the fixed single-axis counter to N channels with configurable width, a configurable drain rate, saturation detection and per-channel zeroing.

---
 rtl/cdu_pkg.sv | 35 +++
 rtl/cdu_count_chan.sv | 57 +++++
 rtl/cdu_count_bank.sv | 53 +++++
 3 files changed

// File: rtl/cdu_pkg.sv
// Shared constants and the saturating pending-counter update for the CDU counter bank.
package cdu_pkg;

  localparam int CDU_PPS_DIV = 16;
  localparam int CDU_CW      = 16;
  localparam int CDU_PW      = 8;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] val;
  } cdu_sat_t;

  // pend + d - e, clamped to the symmetric range +/-(2^(pw-1)-1); sat flags a clamp.
  function automatic cdu_sat_t cdu_sat_add(input logic signed [31:0] pend,
                                           input logic signed [1:0]  d,
                                           input logic signed [1:0]  e,
                                           input int                 pw);
    logic signed [31:0] lim;
    logic signed [31:0] sum;
    cdu_sat_t           r;
    lim   = (32'sd1 <<< (pw - 1)) - 32'sd1;
    sum   = pend + 32'(d) - 32'(e);
    r.sat = 1'b0;
    r.val = sum;
    if (sum > lim) begin
      r.val = lim;
      r.sat = 1'b1;
    end else if (sum < -lim) begin
      r.val = -lim;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdu_count_chan.sv
// One CDU channel: read counter, signed pending counter, sticky saturation and slot-paced drain.
module cdu_count_chan
  import cdu_pkg::*;
#(
  parameter int CW = CDU_CW,
  parameter int PW = CDU_PW
) (
  input  logic          CLOCKH,
  input  logic          rst,
  input  logic          slot,
  input  logic          out_en,
  input  logic          inc_up,
  input  logic          inc_dn,
  input  logic          zero,
  output logic          cnt_up,
  output logic          cnt_dn,
  output logic [CW-1:0] angle,
  output logic          ovf
);

  logic signed [PW-1:0] pend;
  logic signed [1:0]    d;
  logic signed [1:0]    e;
  logic                 drain;
  cdu_sat_t             nxt;
  logic                 hi_unused;

  always_comb begin
    d = 2'sb00;
    if (inc_up && !inc_dn)      d = 2'sb01;
    else if (inc_dn && !inc_up) d = 2'sb11;
    // drain decision uses the registered pending value, never this cycle's increment
    drain = slot && out_en && (pend != '0);
    e     = 2'sb00;
    if (drain) e = pend[PW-1] ? 2'sb11 : 2'sb01;
    nxt   = cdu_sat_add(32'(pend), d, e, PW);
  end

  assign hi_unused = ^nxt.val[31:PW];

  always_ff @(posedge CLOCKH) begin
    if (rst || zero) begin
      angle  <= '0;
      pend   <= '0;
      ovf    <= 1'b0;
      cnt_up <= 1'b0;
      cnt_dn <= 1'b0;
    end else begin
      angle  <= angle + CW'(d);
      pend   <= nxt.val[PW-1:0];
      ovf    <= ovf | nxt.sat;
      cnt_up <= drain && !pend[PW-1];
      cnt_dn <= drain && pend[PW-1];
    end
  end

endmodule

// File: rtl/cdu_count_bank.sv
// N-channel CDU counter bank: shared pulse-slot divider feeding an array of channel instances.
module cdu_count_bank
  import cdu_pkg::*;
#(
  parameter int NCHAN = 3,
  parameter int CW    = CDU_CW,
  parameter int PW    = CDU_PW,
  parameter int DIV   = CDU_PPS_DIV
) (
  input  logic                CLOCKH,
  input  logic                rst,
  input  logic [NCHAN-1:0]    inc_up,
  input  logic [NCHAN-1:0]    inc_dn,
  input  logic [NCHAN-1:0]    zero,
  input  logic                out_en,
  output logic [NCHAN-1:0]    cnt_up,
  output logic [NCHAN-1:0]    cnt_dn,
  output logic [NCHAN*CW-1:0] angle,
  output logic [NCHAN-1:0]    ovf
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]             div;
  logic                      slot;
  logic [NCHAN-1:0][CW-1:0]  angle_q;

  assign slot  = (div == DW'(DIV - 1));
  assign angle = angle_q;

  // free-running slot divider; only reset touches it
  always_ff @(posedge CLOCKH) begin
    if (rst || slot) div <= '0;
    else             div <= div + DW'(1);
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    cdu_count_chan #(.CW(CW), .PW(PW)) u_chan (
      .CLOCKH (CLOCKH),
      .rst    (rst),
      .slot   (slot),
      .out_en (out_en),
      .inc_up (inc_up[i]),
      .inc_dn (inc_dn[i]),
      .zero   (zero[i]),
      .cnt_up (cnt_up[i]),
      .cnt_dn (cnt_dn[i]),
      .angle  (angle_q[i]),
      .ovf    (ovf[i])
    );
  end

endmodule
